// File: rtl/prog_loader_if.sv
// Boot-loader bus: byte stream in, program-memory write port and CPU control out.
// slave is the loader side, master is the host/stream side.
interface prog_loader_if #(
   parameter int WORD_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
) ();
   logic                  start;
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [WORD_WIDTH-1:0] mem_wdata;
   logic                  cpu_rst;
   logic                  busy;
   logic                  done;
   logic [1:0]            err;

   modport master (
      output start, in_data, in_valid,
      input  in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err
   );

   modport slave (
      input  start, in_data, in_valid,
      output in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err
   );
endinterface

// File: rtl/prog_loader.sv
// Hardware boot path: receives a length/checksum framed byte stream, writes the
// assembled words to program memory and keeps the CPU in reset until the load verifies.
module prog_loader #(
   parameter int WORD_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 16,
   parameter int RST_HOLD       = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input logic          clk,
   input logic          rst,
   prog_loader_if.slave bus
);
   localparam int BPW    = WORD_WIDTH / 8;
   localparam int IDX_W  = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int HOLD_W = $clog2(RST_HOLD + 1);
   localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [32:0] CAP = 33'd1 << ADDR_WIDTH;

   localparam logic [2:0] S_HOLD   = 3'd0;
   localparam logic [2:0] S_IDLE   = 3'd1;
   localparam logic [2:0] S_LEN_HI = 3'd2;
   localparam logic [2:0] S_LEN_LO = 3'd3;
   localparam logic [2:0] S_DATA   = 3'd4;
   localparam logic [2:0] S_CSUM   = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;
   localparam logic [2:0] S_ERROR  = 3'd7;

   logic [2:0]            state_q, state_d;
   logic [HOLD_W-1:0]     hold_q, hold_d;
   logic                  load_ok_q, load_ok_d;
   logic [7:0]            len_hi_q, len_hi_d;
   logic [15:0]           rem_q, rem_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [WORD_WIDTH-1:0] word_q, word_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            csum_q, csum_d;
   logic [TO_W-1:0]       to_q, to_d;
   logic [1:0]            err_q, err_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [WORD_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

   logic                  busy;
   logic                  accept;
   logic [HOLD_W-1:0]     hold_last;
   logic [15:0]           len_n;
   logic [WORD_WIDTH-1:0] word_nx;

   assign busy    = (state_q >= S_LEN_HI) && (state_q <= S_CSUM);
   assign accept  = busy && bus.in_valid;
   assign len_n   = {len_hi_q, bus.in_data};
   assign word_nx = (word_q << 8) | WORD_WIDTH'(bus.in_data);
   // One extra settle cycle after a verified load before the CPU is released
   assign hold_last = load_ok_q ? HOLD_W'(RST_HOLD) : HOLD_W'(RST_HOLD - 1);

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      load_ok_d   = load_ok_q;
      len_hi_d    = len_hi_q;
      rem_d       = rem_q;
      idx_d       = idx_q;
      word_d      = word_q;
      addr_d      = addr_q;
      csum_d      = csum_q;
      to_d        = to_q;
      err_d       = err_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      if (busy) to_d = accept ? '0 : to_q + 1'b1;

      case (state_q)
         S_HOLD: begin
            if (hold_q == hold_last) begin
               state_d = load_ok_q ? S_DONE : S_IDLE;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         S_IDLE, S_DONE, S_ERROR: begin
            if (bus.start) begin
               state_d   = S_LEN_HI;
               err_d     = 2'd0;
               load_ok_d = 1'b0;
               addr_d    = '0;
               csum_d    = 8'd0;
               idx_d     = '0;
               to_d      = '0;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               len_hi_d = bus.in_data;
               csum_d   = csum_q ^ bus.in_data;
               state_d  = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               csum_d = csum_q ^ bus.in_data;
               rem_d  = len_n;
               if ({17'd0, len_n} > CAP) begin
                  state_d = S_ERROR;
                  err_d   = 2'd2;
               end else if (len_n == 16'd0) begin
                  state_d = S_CSUM;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               csum_d = csum_q ^ bus.in_data;
               word_d = word_nx;
               if (idx_q == IDX_W'(BPW - 1)) begin
                  idx_d       = '0;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = addr_q;
                  mem_wdata_d = word_nx;
                  addr_d      = addr_q + 1'b1;
                  rem_d       = rem_q - 16'd1;
                  if (rem_q == 16'd1) state_d = S_CSUM;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_CSUM: begin
            if (accept) begin
               if (bus.in_data == csum_q) begin
                  state_d   = S_HOLD;
                  hold_d    = '0;
                  load_ok_d = 1'b1;
               end else begin
                  state_d = S_ERROR;
                  err_d   = 2'd1;
               end
            end
         end
         default: state_d = S_HOLD;
      endcase

      // An accepted byte in the expiry cycle takes priority over the timeout
      if (busy && !accept && (to_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
         state_d = S_ERROR;
         err_d   = 2'd3;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_HOLD;
         hold_q      <= '0;
         load_ok_q   <= 1'b0;
         len_hi_q    <= 8'd0;
         rem_q       <= 16'd0;
         idx_q       <= '0;
         word_q      <= '0;
         addr_q      <= '0;
         csum_q      <= 8'd0;
         to_q        <= '0;
         err_q       <= 2'd0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         load_ok_q   <= load_ok_d;
         len_hi_q    <= len_hi_d;
         rem_q       <= rem_d;
         idx_q       <= idx_d;
         word_q      <= word_d;
         addr_q      <= addr_d;
         csum_q      <= csum_d;
         to_q        <= to_d;
         err_q       <= err_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.in_ready  = busy;
   assign bus.busy      = busy;
   assign bus.cpu_rst   = !((state_q == S_IDLE) || (state_q == S_DONE));
   assign bus.done      = (state_q == S_DONE);
   assign bus.err       = err_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader with a frame-level reference model and
// literal expectations for the documented scenarios.
module tb_prog_loader;
   localparam int WW   = 16;
   localparam int AW   = 4;
   localparam int HOLD = 4;
   localparam int TO   = 100;
   localparam int BPW  = WW / 8;
   localparam int CAPW = 1 << AW;

   localparam int PH_HOLD = 0;
   localparam int PH_IDLE = 1;
   localparam int PH_LOAD = 2;
   localparam int PH_DONE = 3;
   localparam int PH_ERR  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   chk = 0;
   int   fail = 0;

   prog_loader_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

   prog_loader #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .RST_HOLD(HOLD), .TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk++;
      if (act !== exp) begin
         fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (frame level) ----------------
   int          m_phase = PH_HOLD;
   int          m_hold  = HOLD;
   bit          m_ok    = 1'b0;
   int          m_err   = 0;
   int          m_idle  = 0;
   int          m_n     = 0;
   bit          m_we    = 1'b0;
   int          m_waddr = 0;
   int          m_wdata = 0;
   logic [7:0]  m_bytes[$];
   int          mb_cnt, mb_w;
   logic [7:0]  mb_x;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = PH_HOLD; m_hold = HOLD; m_ok = 1'b0; m_err = 0;
         m_we = 1'b0; m_waddr = 0; m_wdata = 0;
      end else begin
         m_we = 1'b0;
         case (m_phase)
            PH_HOLD: begin
               m_hold--;
               if (m_hold == 0) m_phase = m_ok ? PH_DONE : PH_IDLE;
            end
            PH_IDLE, PH_DONE, PH_ERR: begin
               if (bus.start) begin
                  m_phase = PH_LOAD; m_err = 0; m_ok = 1'b0; m_idle = 0;
                  m_bytes.delete();
               end
            end
            PH_LOAD: begin
               if (bus.in_valid) begin
                  m_bytes.push_back(bus.in_data);
                  m_idle = 0;
                  mb_cnt = m_bytes.size();
                  if (mb_cnt == 2) begin
                     m_n = {m_bytes[0], m_bytes[1]};
                     if (m_n > CAPW) begin m_phase = PH_ERR; m_err = 2; end
                  end else if (mb_cnt > 2) begin
                     if (mb_cnt - 2 <= m_n * BPW) begin
                        if ((mb_cnt - 2) % BPW == 0) begin
                           mb_w    = (mb_cnt - 2) / BPW - 1;
                           m_we    = 1'b1;
                           m_waddr = mb_w;
                           m_wdata = 0;
                           for (int i = 0; i < BPW; i++)
                              m_wdata = (m_wdata << 8) | m_bytes[2 + mb_w * BPW + i];
                        end
                     end else begin
                        mb_x = 8'd0;
                        for (int i = 0; i < mb_cnt - 1; i++) mb_x = mb_x ^ m_bytes[i];
                        if (mb_x == m_bytes[mb_cnt - 1]) begin
                           m_phase = PH_HOLD; m_hold = HOLD + 1; m_ok = 1'b1;
                        end else begin
                           m_phase = PH_ERR; m_err = 1;
                        end
                     end
                  end
               end else begin
                  m_idle++;
                  if (m_idle == TO) begin m_phase = PH_ERR; m_err = 3; end
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      check("in_ready", bus.in_ready, m_phase == PH_LOAD);
      check("busy",     bus.busy,     m_phase == PH_LOAD);
      check("cpu_rst",  bus.cpu_rst,  !(m_phase == PH_IDLE || m_phase == PH_DONE));
      check("done",     bus.done,     m_phase == PH_DONE);
      check("err",      bus.err,      m_err);
      check("mem_we",   bus.mem_we,   m_we);
      if (m_we) begin
         check("mem_addr",  bus.mem_addr,  m_waddr);
         check("mem_wdata", bus.mem_wdata, m_wdata);
      end
   end

   // Write log observed at the memory port
   int log_addr[$];
   int log_data[$];
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         log_addr.push_back(bus.mem_addr);
         log_data.push_back(bus.mem_wdata);
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [7:0] txq[$];

   task automatic pulse_start();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int maxgap);
      int  g;
      bit  r;
      g = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
      repeat (g) begin @(posedge clk); #1; end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      r = 1'b0;
      for (int i = 0; i < 50 && !r; i++) begin
         @(negedge clk); r = bus.in_ready;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      if (!r) check("byte_accept_timeout", 0, 1);
   endtask

   task automatic send_txq(input int maxgap);
      foreach (txq[i]) send_byte(txq[i], maxgap);
   endtask

   task automatic wait_end();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (bus.done || bus.err != 2'd0) seen = 1'b1;
      end
      if (!seen) check("wait_end_timeout", 0, 1);
   endtask

   task automatic load_good_frame();
      txq = '{8'h00, 8'h03, 8'h40, 8'h41, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, nlog, n;
      bit bad, seen;
      logic [7:0] x, b;
      bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;

      // Reset: cpu_rst held for exactly HOLD edges after release
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_addr",  bus.mem_addr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      rst = 1'b0;
      cnt = 0; seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         check("rst_in_ready", bus.in_ready, 0);
         if (bus.cpu_rst) cnt++; else seen = 1'b1;
      end
      check("rst_hold_cycles", cnt, 4);
      check("rst_no_writes", log_addr.size(), 0);

      // Good load with random gaps
      @(posedge clk); #1;
      pulse_start();
      load_good_frame();
      send_txq(2);
      cnt = 0; seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1; else cnt++;
      end
      check("good_done_latency", cnt, 5);
      check("good_cpu_rst", bus.cpu_rst, 0);
      check("good_err", bus.err, 0);
      check("good_nwrites", log_addr.size(), 3);
      if (log_addr.size() == 3) begin
         check("good_w0", {log_addr[0][15:0], log_data[0][15:0]}, 32'h0000_4041);
         check("good_w1", {log_addr[1][15:0], log_data[1][15:0]}, 32'h0001_1234);
         check("good_w2", {log_addr[2][15:0], log_data[2][15:0]}, 32'h0002_ABCD);
      end

      // Bad checksum, then recovery with the good frame
      pulse_start();
      load_good_frame();
      txq[8] = 8'h43;
      send_txq(1);
      @(negedge clk);
      check("bad_err", bus.err, 1);
      check("bad_cpu_rst", bus.cpu_rst, 1);
      check("bad_done", bus.done, 0);
      pulse_start();
      load_good_frame();
      send_txq(1);
      wait_end();
      check("recover_done", bus.done, 1);
      check("recover_err", bus.err, 0);

      // Empty load
      nlog = log_addr.size();
      pulse_start();
      txq = '{8'h00, 8'h00, 8'h00};
      send_txq(0);
      wait_end();
      check("empty_done", bus.done, 1);
      check("empty_nwrites", log_addr.size(), nlog);

      // Oversize length (17 words into a 16-word memory)
      nlog = log_addr.size();
      pulse_start();
      txq = '{8'h00, 8'h11};
      send_txq(0);
      @(negedge clk);
      check("oversize_err", bus.err, 2);
      check("oversize_in_ready", bus.in_ready, 0);
      check("oversize_nwrites", log_addr.size(), nlog);

      // Timeout, with an ignored start pulse while busy
      pulse_start();
      txq = '{8'h00, 8'h01, 8'h40};
      send_txq(0);
      cnt = 0; seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         bus.start = (i == 10);
         if (bus.err == 2'd3) seen = 1'b1; else cnt++;
      end
      bus.start = 1'b0;
      check("timeout_cycles", cnt, 100);

      // Reset asserted in the middle of a data word
      @(posedge clk); #1;
      pulse_start();
      txq = '{8'h00, 8'h02, 8'h40, 8'h41, 8'h12};
      send_txq(0);
      rst = 1'b1;
      #1;
      check("midrst_cpu_rst", bus.cpu_rst, 1);
      check("midrst_in_ready", bus.in_ready, 0);
      check("midrst_busy", bus.busy, 0);
      check("midrst_mem_we", bus.mem_we, 0);
      check("midrst_mem_addr", bus.mem_addr, 0);
      check("midrst_mem_wdata", bus.mem_wdata, 0);
      check("midrst_done", bus.done, 0);
      check("midrst_err", bus.err, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (!bus.cpu_rst) seen = 1'b1;
      end
      check("midrst_release", seen, 1);

      // Randomized frames
      for (int t = 0; t < 14; t++) begin
         n   = ($urandom_range(7, 0) == 0) ? $urandom_range(20, 17) : $urandom_range(6, 0);
         bad = ($urandom_range(3, 0) == 0);
         txq.delete();
         txq.push_back(8'(n >> 8));
         txq.push_back(8'(n));
         if (n <= CAPW) begin
            for (int i = 0; i < n * BPW; i++) begin
               b = 8'($urandom);
               txq.push_back(b);
            end
            x = 8'd0;
            foreach (txq[i]) x = x ^ txq[i];
            txq.push_back(bad ? (x ^ 8'(1 << $urandom_range(7, 0))) : x);
         end
         pulse_start();
         send_txq(3);
         wait_end();
         if (n > CAPW)   check("rand_err_len", bus.err, 2);
         else if (bad)   check("rand_err_csum", bus.err, 1);
         else            check("rand_done", bus.done, 1);
      end

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", chk, fail);
      $finish;
   end
endmodule

// File: doc/prog_loader.md
# prog_loader

Synthesizable program loader that replaces simulation-only memory preloading with a hardware boot path. It accepts a framed byte stream over a valid/ready handshake (typically from a UART receiver) and assembles bytes into WORD_WIDTH-bit instruction words. It writes those words to CPU program memory at consecutive addresses and holds the CPU in reset for the whole load. It releases the CPU only after a length-checked, checksum-verified load completes.

## Interface
- WORD_WIDTH, 16: instruction word width; must be a multiple of 8; BPW = WORD_WIDTH/8 bytes per word.
- ADDR_WIDTH, 16: memory address width; capacity = 2**ADDR_WIDTH words.
- RST_HOLD, 4: cycles cpu_rst stays high after reset or after a successful load; must be ≥1.
- TIMEOUT_CYCLES, 1000000: maximum idle cycles between accepted bytes while receiving.
- CLK  in  1  sole clock.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  one-cycle write strobe.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_wdata  out  WORD_WIDTH  write data.
- cpu_rst  out  1  CPU reset, active-high.
- busy  out  1  load in progress (states LEN_HI through CSUM).
- done  out  1  last load succeeded.
- err  out  2  error code: 0 none, 1 checksum mismatch, 2 length exceeds capacity, 3 timeout.

## Operation
- Frame format, big-endian: LEN_HI, LEN_LO (16-bit word count N), then N×BPW data bytes (MSB first per word), then one checksum byte.
- Checksum is the XOR of every frame byte preceding it, length bytes included.
- A byte is accepted only when in_valid && in_ready.
- in_ready is 1 only in LEN_HI, LEN_LO, DATA, and CSUM.
- State HOLD: cpu_rst=1; counts RST_HOLD cycles, then goes to IDLE after reset, or to DONE after a successful load.
- State IDLE: cpu_rst=0, done=0. start → LEN_HI.
- States LEN_HI, LEN_LO: capture N.
  - If N > 2**ADDR_WIDTH → ERROR with err=2; no writes occur.
  - If N = 0 → CSUM.
  - Otherwise → DATA.
- State DATA: shift each byte into the word assembler.
  - On the BPW-th byte, a registered write is issued at the current address, then the address increments.
  - After word N → CSUM.
- State CSUM: on a match → HOLD; on a mismatch → ERROR with err=1.
- State DONE: done=1, cpu_rst=0.
- State ERROR: cpu_rst=1, done=0; err holds its value.
- start is accepted only in IDLE, DONE, or ERROR. On acceptance:
  - clear err and done, set cpu_rst=1;
  - reset the address to 0, the checksum accumulator to 0, and the byte index to 0;
  - go to LEN_HI.
- start is ignored while busy.
- Timeout: a counter clears on every accepted byte and on entry to LEN_HI. It increments each cycle in LEN_HI through CSUM. On reaching TIMEOUT_CYCLES → ERROR with err=3.
- Memory written before an error is not rolled back.
- Address wrap cannot occur, because N ≤ capacity is enforced before any writes.

## Timing
- Reset values: state HOLD (hold counter 0), cpu_rst=1, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0.
- After RST deasserts, cpu_rst stays 1 for exactly RST_HOLD rising edges, then the state is IDLE with cpu_rst=0.
- start sampled high at edge k → state LEN_HI and in_ready=1 after edge k.
- The final byte of a word accepted at edge k → mem_we=1 with valid mem_addr/mem_wdata for exactly the cycle after edge k.
- Back-to-back bytes are accepted every cycle, so the sustained rate is one byte per cycle.
- Checksum byte accepted at edge k:
  - on a match, cpu_rst falls and done rises together, RST_HOLD+1 edges later;
  - on a mismatch, err is valid the cycle after edge k.
- Assertion of RST at any point aborts the load immediately and all outputs return to their reset values.
- A byte and a timeout expiry in the same cycle: the byte wins and the counter clears.

## Test plan
- Reset: pulse RST, RST_HOLD=4 → cpu_rst=1 for 4 cycles after release, then 0; in_ready=0; mem_we never asserted.
- Good load, WORD_WIDTH=16: start, then stream 00 03 40 41 12 34 AB CD 42, with random in_valid gaps → writes 0→0x4041, 1→0x1234, 2→0xABCD, each a single mem_we pulse; done=1 and cpu_rst=0 five cycles after the checksum byte; err=0.
- Bad checksum: the same frame ending in 43 → err=1; cpu_rst stays 1; done=0. A subsequent start plus the good frame → done=1, err=0.
- Empty load: 00 00 00 → no mem_we pulse; done=1.
- Oversize length, ADDR_WIDTH=4: 00 11 → err=2 after the second byte; zero writes; in_ready=0.
- Timeout with TIMEOUT_CYCLES=100: send 00 01 40, then hold in_valid=0 → err=3 exactly 100 cycles after the last byte is accepted. start during busy has no effect. RST asserted mid-DATA → immediate reset values.
